// File: rtl/seq_multiplier_32bit.sv
// Sequential unsigned 32x32 shift-add multiplier: one partial product per clock,
// 64-bit product held in registers between operations for the ALU result mux.
module seq_multiplier_32bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [64:0] acc;
  logic [64:0] acc_step;
  logic [31:0] mcand;
  logic [4:0]  count;
  logic [63:0] result;

  // Bit 64 is the carry slot; it is always zero after a shift, so adding it
  // into the high word keeps the sum a clean 33-bit value.
  function automatic logic [64:0] shift_add_step(input logic [64:0] acc_in,
                                                 input logic [31:0] mc);
    logic [32:0] sum;
    if (acc_in[0])
      sum = acc_in[64:32] + {1'b0, mc};
    else
      sum = acc_in[64:32];
    return {1'b0, sum, acc_in[31:1]};
  endfunction

  assign acc_step = shift_add_step(acc, mcand);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The product is captured on the final iteration so it is already settled
  // while done is high, as downstream logic samples it in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {1'b0, 32'b0, b};
            count <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          if (count == 5'd31)
            result <= acc_step[63:0];
          else
            count <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign result_lo = result[31:0];
  assign result_hi = result[63:32];

endmodule
